// File: rtl/melody_sequencer.sv
// Purpose: steps through a {hz, dur} score ROM and drives a tone frequency to a buzzer player.
// Latency: 2 cycles (FETCH, LATCH) per entry before its note sounds; each note lasts dur*UNIT_CYCLES.
// Backpressure: none on the score ROM; 'pause' freezes PLAY/GAP counting and mutes hz while high.
// Optional feature: define MELODY_GAP_EN to insert one silent unit after every note.
module melody_sequencer #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int UNIT_MS = 10,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] score_addr,
    input  logic [19:0]       score_data,
    output logic [11:0]       hz,
    output logic              busy,
    output logic              done
);

    localparam int          UNIT_CYCLES = CLK_HZ / 1000 * UNIT_MS;
    localparam logic [31:0] UNIT_LAST   = 32'(UNIT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PLAY
`ifdef MELODY_GAP_EN
        , S_GAP
`endif
    } state_t;

    state_t      state;
    logic [11:0] hz_q;
    logic [31:0] unit_cnt;
    logic [7:0]  remaining;

    logic [11:0] entry_hz;
    logic [7:0]  entry_dur;

    assign entry_hz  = score_data[19:8];
    assign entry_dur = score_data[7:0];

    // Busy is a pure decode of the state register.
    assign busy = (state != S_IDLE);

    // Pause mutes the current note immediately while keeping it in hz_q for release;
    // GAP already drives hz_q to zero, so only PLAY needs masking.
    assign hz = (pause && (state == S_PLAY)) ? 12'd0 : hz_q;

    // Playback state machine: score walking, note timing, stop/loop/end handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            score_addr <= '0;
            hz_q       <= 12'd0;
            unit_cnt   <= 32'd0;
            remaining  <= 8'd0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                // Abort wins over everything, including a same-cycle start.
                state     <= S_IDLE;
                hz_q      <= 12'd0;
                unit_cnt  <= 32'd0;
                remaining <= 8'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            score_addr <= '0;
                            state      <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        // ROM read is in flight; hz keeps the previous note to avoid a click.
                        state <= S_LATCH;
                    end
                    S_LATCH: begin
                        if (entry_dur == 8'd0) begin
                            // Looping a score whose first entry is the marker would spin forever,
                            // so that case ends playback like a normal end of score.
                            if (loop_en && (score_addr != '0)) begin
                                score_addr <= '0;
                                state      <= S_FETCH;
                            end else begin
                                state <= S_IDLE;
                                hz_q  <= 12'd0;
                                done  <= 1'b1;
                            end
                        end else begin
                            hz_q      <= entry_hz;
                            unit_cnt  <= 32'd0;
                            remaining <= entry_dur;
                            state     <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (!pause) begin
                            if (unit_cnt == UNIT_LAST) begin
                                unit_cnt  <= 32'd0;
                                remaining <= remaining - 8'd1;
                                if (remaining == 8'd1) begin
                                    score_addr <= score_addr + ADDR_ONE;
`ifdef MELODY_GAP_EN
                                    hz_q  <= 12'd0;
                                    state <= S_GAP;
`else
                                    state <= S_FETCH;
`endif
                                end
                            end else begin
                                unit_cnt <= unit_cnt + 32'd1;
                            end
                        end
                    end
`ifdef MELODY_GAP_EN
                    S_GAP: begin
                        if (!pause) begin
                            if (unit_cnt == UNIT_LAST) begin
                                unit_cnt <= 32'd0;
                                state    <= S_FETCH;
                            end else begin
                                unit_cnt <= unit_cnt + 32'd1;
                            end
                        end
                    end
`endif
                    default: begin
                        state <= S_IDLE;
                        hz_q  <= 12'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Purpose: self-checking bench for melody_sequencer with a run-length scoreboard of hz.
// Latency: scoreboard expects 2 cycles of fetch per entry, dur*100 cycles per note.
// Backpressure: none; pause is exercised as a stimulus level.
module tb_melody_sequencer;

    localparam int CLK_HZ  = 100_000;
    localparam int UNIT_MS = 1;
    localparam int U       = 100;
`ifdef MELODY_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        pause;
    logic        loop_en;
    logic [7:0]  score_addr;
    logic [19:0] score_data;
    logic [11:0] hz;
    logic        busy;
    logic        done;

    logic        start2;
    logic        stop2;
    logic [1:0]  score_addr2;
    logic [19:0] score_data2;
    logic [11:0] hz2;
    logic        busy2;
    logic        done2;

    logic [19:0] rom  [256];
    logic [19:0] rom2 [4];

    melody_sequencer #(.CLK_HZ(CLK_HZ), .UNIT_MS(UNIT_MS), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .score_addr(score_addr), .score_data(score_data),
        .hz(hz), .busy(busy), .done(done)
    );

    melody_sequencer #(.CLK_HZ(CLK_HZ), .UNIT_MS(UNIT_MS), .ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .pause(pause),
        .loop_en(loop_en), .score_addr(score_addr2), .score_data(score_data2),
        .hz(hz2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous score ROMs: data valid one cycle after the address.
    always @(posedge clk) begin
        score_data  <= rom[score_addr];
        score_data2 <= rom2[score_addr2];
    end

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int hz;
        int len;
    } run_t;

    run_t exp_q[$];
    int   m_hz;
    int   m_len;
    int   exp_total;

    task automatic sb_push(input int h, input int n);
        run_t r;
        if (n == 0) return;
        exp_total += n;
        if (m_len > 0 && h == m_hz) begin
            m_len += n;
        end else begin
            if (m_len > 0) begin
                r.hz  = m_hz;
                r.len = m_len;
                exp_q.push_back(r);
            end
            m_hz  = h;
            m_len = n;
        end
    endtask

    // Expected hz trace of a non-looping score, as runs of equal value.
    task automatic build_expected();
        int  cur;
        run_t r;
        exp_q.delete();
        m_len     = 0;
        m_hz      = 0;
        exp_total = 0;
        cur       = 0;
        for (int a = 0; a < 256; a++) begin
            sb_push(cur, 2);
            if (rom[a][7:0] == 8'd0) break;
            cur = int'(rom[a][19:8]);
            sb_push(cur, int'(rom[a][7:0]) * U);
            if (GAP) begin
                sb_push(0, U);
                cur = 0;
            end
        end
        if (m_len > 0) begin
            r.hz  = m_hz;
            r.len = m_len;
            exp_q.push_back(r);
        end
    endtask

    task automatic compare_run(input int h, input int n);
        run_t r;
        if (exp_q.size() == 0) begin
            check("extra_run", 1, 0);
        end else begin
            r = exp_q.pop_front();
            check("run_hz", h, r.hz);
            check("run_len", n, r.len);
        end
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = 20'd0;
    endtask

    // Plays the score in rom to its natural end and compares hz runs against the model.
    task automatic run_score();
        int  cur;
        int  len;
        bit  got_done;
        build_expected();
        got_done = 1'b0;
        cur      = 0;
        len      = 0;
        start    = 1'b1;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (done) begin
                compare_run(cur, len);
                check("done_cycle", i, exp_total + 1);
                check("hz_at_done", hz, 0);
                check("busy_at_done", busy, 0);
                got_done = 1'b1;
                break;
            end
            if (i == 1) begin
                cur = hz;
                len = 1;
            end else if (hz == cur) begin
                len++;
            end else begin
                compare_run(cur, len);
                cur = hz;
                len = 1;
            end
            // A start in the middle of a note must be ignored.
            start = (i == 50);
        end
        start = 1'b0;
        if (!got_done) check("done_timeout", 0, 1);
        check("runs_left", exp_q.size(), 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    int k, end_k, pz_bad, done_bad, busy_bad, returns, hz440, first_k;
    bit wrapped, seen_new;
    logic [1:0] prev_a2;
    logic [7:0] prev_a;
    int new_hz;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        pause    = 1'b0;
        loop_en  = 1'b0;
        start2   = 1'b0;
        stop2    = 1'b0;
        clear_rom();
        for (int a = 0; a < 4; a++) rom2[a] = 20'd0;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_hz", hz, 0);
        check("rst_done", done, 0);
        check("rst_addr", score_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Main score: note, rest, note, end marker.
        rom[0] = {12'd440, 8'd2};
        rom[1] = {12'd0,   8'd1};
        rom[2] = {12'd523, 8'd3};
        rom[3] = {12'd0,   8'd0};
        run_score();

        // Pause for 50 cycles starting after cycle 30 of a one-unit note.
        clear_rom();
        rom[0] = {12'd440, 8'd1};
        start  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        first_k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (hz == 12'd440) begin
                first_k = 1;
                break;
            end
        end
        check("pause_note_start", first_k, 1);
        k      = 1;
        end_k  = 0;
        pz_bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            k++;
            if (k == 30) check("hz_before_pause", hz, 440);
            if (k >= 31 && k <= 80 && hz != 12'd0) pz_bad++;
            if (k == 81) check("hz_after_pause", hz, 440);
            if (score_addr == 8'd1 && end_k == 0) end_k = k - 1;
            pause = (k >= 30 && k < 80);
            if (done) break;
        end
        pause = 1'b0;
        check("pause_hz_zero", pz_bad, 0);
        check("paused_note_len", end_k, 150);
        repeat (3) @(negedge clk);

        // Looping score never finishes and keeps returning to entry 0.
        rom[0]   = {12'd440, 8'd1};
        loop_en  = 1'b1;
        start    = 1'b1;
        done_bad = 0;
        busy_bad = 0;
        returns  = 0;
        hz440    = 0;
        prev_a   = 8'd0;
        for (int i = 0; i < 420; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_bad++;
            if (!busy) busy_bad++;
            if (hz == 12'd440) hz440++;
            if (prev_a == 8'd1 && score_addr == 8'd0) returns++;
            prev_a = score_addr;
        end
        check("loop_no_done", done_bad, 0);
        check("loop_busy", busy_bad, 0);
        check("loop_wraps", returns >= 2, 1);
        check("loop_hz440", hz440 >= 200, 1);

        // Stop together with start mid-note.
        for (int i = 0; i < 300; i++) begin
            if (hz == 12'd440 && !pause) break;
            @(negedge clk);
        end
        stop  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
        start = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_hz", hz, 0);
        check("stop_done", done, 0);
        done_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) done_bad++;
        end
        check("stop_stays_idle", done_bad, 0);

        // Marker at entry 0 with looping enabled ends playback with done.
        clear_rom();
        start   = 1'b1;
        first_k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                first_k = i;
                break;
            end
        end
        check("empty_loop_done", first_k, 3);
        check("empty_loop_busy", busy, 0);
        loop_en = 1'b0;
        @(negedge clk);

        // Reset mid-note discards playback.
        rom[0] = {12'd440, 8'd2};
        rom[1] = {12'd0,   8'd1};
        rom[2] = {12'd523, 8'd3};
        rom[3] = {12'd0,   8'd0};
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (120) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hz", hz, 0);
        check("arst_done", done, 0);
        check("arst_addr", score_addr, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        done_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done || busy) done_bad++;
        end
        check("arst_no_resume", done_bad, 0);

        // Two-bit address, no end marker: address wraps 3 -> 0 and playback continues.
        rom2[0] = {12'd100, 8'd1};
        rom2[1] = {12'd200, 8'd1};
        rom2[2] = {12'd300, 8'd1};
        rom2[3] = {12'd400, 8'd1};
        start2   = 1'b1;
        wrapped  = 1'b0;
        seen_new = 1'b0;
        new_hz   = 0;
        done_bad = 0;
        prev_a2  = 2'd0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done2) done_bad++;
            if (prev_a2 == 2'd3 && score_addr2 == 2'd0) wrapped = 1'b1;
            prev_a2 = score_addr2;
            if (wrapped && !seen_new && hz2 != 12'd400 && hz2 != 12'd0) begin
                seen_new = 1'b1;
                new_hz   = int'(hz2);
                break;
            end
        end
        check("wrap_seen", wrapped, 1);
        check("wrap_replay_hz", new_hz, 100);
        check("wrap_busy", busy2, 1);
        check("wrap_no_done", done_bad, 0);
        stop2 = 1'b1;
        @(negedge clk);
        stop2 = 1'b0;
        check("wrap_stop", busy2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
